// File: rtl/hidden_output_collector.sv
// hidden_output_collector
// Collects the per-neuron activation outputs of the hidden layer into one
// vector per frame. It then streams that vector, neuron 0 first, to the next
// layer over a valid/ready interface. Two banks are used as a ping-pong pair,
// so a new frame can be captured while the previous frame drains.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     [numNeurons]            bit i = outvalid pulse of neuron i
//   in_data      [numNeurons*dataWidth]  neuron i word at [i*dataWidth +: dataWidth]
//   out_data     [dataWidth]             current serialized element (registered)
//   out_valid    out_data is valid
//   out_ready    downstream accepts out_data
//   out_last     high with out_valid on element numNeurons-1
//   overflow     sticky: a capture was dropped or duplicated
//   overflow_clr clears overflow (a new error on the same edge wins)
//
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both high. Once out_valid is raised, it stays high, and out_data and
// out_last stay unchanged, until that transfer happens. out_valid never
// depends combinationally on out_ready.

module hidden_output_collector #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16,
  parameter int idxWidth   = $clog2(numNeurons)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons-1:0]           in_valid,
  input  logic [numNeurons*dataWidth-1:0] in_data,
  output logic [dataWidth-1:0]            out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            overflow,
  input  logic                            overflow_clr
);

  localparam logic [idxWidth-1:0] LAST_IDX = idxWidth'(numNeurons - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;

  // Storage: bank[b][i] holds word i of bank b. There is one capture mask
  // and one full flag per bank.
  logic [1:0][numNeurons-1:0][dataWidth-1:0] bank;
  logic [1:0][numNeurons-1:0]                mask;
  logic [1:0]                                bank_full;
  logic                                      wr_sel;
  logic                                      rd_sel;

  rd_state_t                                 rd_state;
  logic [idxWidth-1:0]                       idx;

  // Capture-side decode. Every term looks at bank_full as it was before this
  // edge. A bank freed on this edge therefore starts accepting captures on
  // the next edge.
  logic [numNeurons-1:0] cur_mask;
  logic [numNeurons-1:0] new_bits;
  logic [numNeurons-1:0] merged;
  logic                  wr_full;
  logic                  frame_done;
  logic                  dup_hit;
  logic                  drop_hit;
  logic                  accept;
  logic                  drain_done;
  logic [idxWidth-1:0]   idx_nxt;

  always_comb begin
    cur_mask   = mask[wr_sel];
    wr_full    = bank_full[wr_sel];
    new_bits   = wr_full ? '0 : (in_valid & ~cur_mask);
    merged     = cur_mask | new_bits;
    frame_done = !wr_full && (merged == '1);
    // The first value wins. A repeat pulse is reported and is not stored.
    dup_hit    = !wr_full && (|(in_valid & cur_mask));
    // Both banks are occupied, so every arriving pulse is lost.
    drop_hit   = wr_full && (|in_valid);
    accept     = out_valid && out_ready;
    drain_done = (rd_state == ST_STREAM) && accept && (idx == LAST_IDX);
    idx_nxt    = idx + idxWidth'(1);
  end

  // Capture path, bank bookkeeping and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank      <= '0;
      mask      <= '0;
      bank_full <= '0;
      wr_sel    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      for (int i = 0; i < numNeurons; i++) begin
        if (new_bits[i]) begin
          bank[wr_sel][i] <= in_data[i*dataWidth +: dataWidth];
        end
      end

      if (frame_done) begin
        mask[wr_sel]      <= '0;
        bank_full[wr_sel] <= 1'b1;
        wr_sel            <= ~wr_sel;
      end else begin
        mask[wr_sel] <= merged;
      end

      // The drain always targets the other bank from a completing capture.
      // wr_sel's bank is empty whenever it completes, and rd_sel's bank is
      // full whenever it drains. Both updates can happen on the same edge.
      if (drain_done) begin
        bank_full[rd_sel] <= 1'b0;
      end

      if (dup_hit || drop_hit) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Read FSM. All outputs are registered and are zero while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state  <= ST_IDLE;
      rd_sel    <= 1'b0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      case (rd_state)
        ST_IDLE: begin
          if (bank_full[rd_sel]) begin
            rd_state  <= ST_STREAM;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= bank[rd_sel][0];
            out_last  <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              // The last word has been taken. Release the bank and pass
              // through IDLE, which costs one bubble cycle.
              rd_state  <= ST_IDLE;
              rd_sel    <= ~rd_sel;
              idx       <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              out_last  <= 1'b0;
            end else begin
              idx      <= idx_nxt;
              out_data <= bank[rd_sel][idx_nxt];
              out_last <= (idx_nxt == LAST_IDX);
            end
          end
        end
        default: begin
          rd_state  <= ST_IDLE;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_output_collector.sv
// Testbench for hidden_output_collector (numNeurons=30, dataWidth=16).
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled on
// the falling edge. The scoreboard queue holds {last, data} expectations.

module tb_hidden_output_collector;

  localparam int N  = 30;
  localparam int W  = 16;
  localparam int EW = W + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;
  logic           overflow;
  logic           overflow_clr;

  logic           fixed_rdy;
  logic           rand_rdy;
  logic           rnd_bit;

  int             total = 0;
  int             bad   = 0;
  int             hs_cnt = 0;
  logic [EW-1:0]  exp_q[$];

  logic           stall_pend = 1'b0;
  logic [EW-1:0]  stall_val  = '0;
  logic           last_pend  = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign out_ready = rand_rdy ? rnd_bit : fixed_rdy;

  always @(posedge clk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  hidden_output_collector #(
    .numNeurons(N),
    .dataWidth (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .overflow    (overflow),
    .overflow_clr(overflow_clr)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and protocol monitor.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      stall_pend = 1'b0;
      last_pend  = 1'b0;
    end else begin
      if (stall_pend) check("stall_hold", 32'({out_last, out_data}), 32'(stall_val));
      if (last_pend)  check("idle_bubble", 32'(out_valid), 32'd0);
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_extra actual=%0h required=none at %0t", {out_last, out_data}, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'({out_last, out_data}), 32'(e));
        end
      end
      stall_pend = out_valid && !out_ready;
      stall_val  = {out_last, out_data};
      last_pend  = out_valid && out_ready && out_last;
    end
  end

  // ---------------- driver tasks ----------------
  // Each driver task is called 1 time unit after a rising edge and returns at
  // the same phase.
  task automatic pulse(input logic [N-1:0] m, input logic [W-1:0] base);
    in_valid = m;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = base + W'(i);
    @(posedge clk); #1;
    in_valid = '0;
  endtask

  task automatic push_frame(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) exp_q.push_back({(i == N-1), base + W'(i)});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- vector table ----------------
  // mode: 0 all neurons in one cycle, 1 serial with neuron 29 first,
  //       2 serial with neuron 0 first, 3 random groups (neuron 0 last)
  typedef struct {
    logic [W-1:0] base;
    int           mode;
    bit           rnd;
    bit           exp_ovf;
    int           exp_beats;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [N-1:0] m;
    logic [N-1:0] lo;
    int           grp[N];
    logic [W-1:0] w;

    vecs[0] = '{base: 16'h0100, mode: 0, rnd: 1'b0, exp_ovf: 1'b0, exp_beats: N};
    vecs[1] = '{base: 16'hA000, mode: 1, rnd: 1'b0, exp_ovf: 1'b0, exp_beats: N};
    vecs[2] = '{base: 16'h4000, mode: 0, rnd: 1'b1, exp_ovf: 1'b0, exp_beats: N};
    vecs[3] = '{base: 16'h5000, mode: 3, rnd: 1'b1, exp_ovf: 1'b0, exp_beats: N};
    vecs[4] = '{base: 16'hFFE0, mode: 2, rnd: 1'b0, exp_ovf: 1'b0, exp_beats: N};

    rst = 1'b1; in_valid = '0; in_data = '0; overflow_clr = 1'b0;
    fixed_rdy = 1'b0; rand_rdy = 1'b0; rnd_bit = 1'b0;
    lo = 30'h0000_7FFF;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    rst = 1'b0;
    tick();

    // ---- table-driven frames ----
    for (int v = 0; v < 5; v++) begin
      fixed_rdy = 1'b1;
      rand_rdy  = vecs[v].rnd;
      hs_cnt    = 0;
      push_frame(vecs[v].base);
      case (vecs[v].mode)
        0: pulse('1, vecs[v].base);
        1: for (int i = N-1; i >= 0; i--) begin m = '0; m[i] = 1'b1; pulse(m, vecs[v].base); end
        2: for (int i = 0; i < N; i++)    begin m = '0; m[i] = 1'b1; pulse(m, vecs[v].base); end
        default: begin
          for (int i = 0; i < N; i++) grp[i] = $urandom_range(0, 3);
          grp[0] = 3;
          for (int s = 0; s < 4; s++) begin
            m = '0;
            for (int i = 0; i < N; i++) if (grp[i] == s) m[i] = 1'b1;
            pulse(m, vecs[v].base);
          end
        end
      endcase
      // The final pulse was sampled at E0. out_valid becomes high after E1.
      check("lat_e0", 32'(out_valid), 32'd0);
      tick();
      check("lat_e1", 32'(out_valid), 32'd1);
      wait_drain(400);
      check("hs_count", 32'(hs_cnt), 32'(vecs[v].exp_beats));
      check("vec_ovf", 32'(overflow), 32'(vecs[v].exp_ovf));
      rand_rdy = 1'b0;
      tick();
    end

    // ---- three back-to-back frames, downstream stalled ----
    fixed_rdy = 1'b0;
    hs_cnt    = 0;
    pulse('1, 16'h1000);
    pulse('1, 16'h2000);
    check("ovf_two_frames", 32'(overflow), 32'd0);
    pulse('1, 16'h3000);
    check("ovf_third_frame", 32'(overflow), 32'd1);
    repeat (3) tick();
    check("stall_head_valid", 32'(out_valid), 32'd1);
    check("stall_head_data",  32'(out_data),  32'h1000);
    push_frame(16'h1000);
    push_frame(16'h2000);
    fixed_rdy = 1'b1;
    wait_drain(400);
    check("hs_two_frames", 32'(hs_cnt), 32'd60);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    check("ovf_cleared_a", 32'(overflow), 32'd0);

    // ---- duplicate capture of neuron 5 ----
    m = '0; m[5] = 1'b1;
    pulse(m, 16'h0050);   // neuron 5 receives 16'h0055
    pulse(m, 16'h0061);   // neuron 5 receives 16'h0066, which must be ignored
    check("ovf_dup", 32'(overflow), 32'd1);
    for (int i = 0; i < N; i++) begin
      w = (i == 5) ? 16'h0055 : (16'hB000 + W'(i));
      exp_q.push_back({(i == N-1), w});
    end
    hs_cnt = 0;
    pulse(~m, 16'hB000);
    wait_drain(400);
    check("hs_dup_frame", 32'(hs_cnt), 32'(N));
    check("ovf_dup_sticky", 32'(overflow), 32'd1);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    check("ovf_cleared_b", 32'(overflow), 32'd0);

    // A new error on the same edge as overflow_clr must win.
    m = '0; m[0] = 1'b1;
    pulse(m, 16'h7000);
    overflow_clr = 1'b1;
    pulse(m, 16'h7100);
    overflow_clr = 1'b0;
    check("ovf_set_over_clr", 32'(overflow), 32'd1);
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    check("ovf_cleared_c", 32'(overflow), 32'd0);
    push_frame(16'h7000);
    pulse(~m, 16'h7000);
    wait_drain(400);

    // ---- reset mid-stream with a second frame half-captured ----
    hs_cnt = 0;
    push_frame(16'hC000);
    pulse('1, 16'hC000);
    pulse(lo, 16'hD000);
    m = '0; m[0] = 1'b1;
    pulse(m, 16'hD000);   // duplicate, so that reset has a set flag to clear
    for (int n = 0; n < 100 && hs_cnt < 10; n++) tick();
    check("reached_beat10", 32'(hs_cnt >= 10), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ovf",   32'(overflow),  32'd0);
    check("mid_rst_last",  32'(out_last),  32'd0);
    check("mid_rst_data",  32'(out_data),  32'd0);
    rst = 1'b0;
    exp_q.delete();
    hs_cnt = 0;
    tick();
    // The upper half alone must not complete a frame. A surviving lower-half
    // mask would make it complete.
    pulse(~lo, 16'hE000);
    repeat (3) tick();
    check("no_residue_valid", 32'(out_valid), 32'd0);
    push_frame(16'hE000);
    pulse(lo, 16'hE000);
    check("post_rst_lat_e0", 32'(out_valid), 32'd0);
    tick();
    check("post_rst_lat_e1", 32'(out_valid), 32'd1);
    wait_drain(400);
    check("hs_post_rst", 32'(hs_cnt), 32'(N));
    check("ovf_post_rst", 32'(overflow), 32'd0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
